// File: rtl/gpu_spi_frontend_multi.sv
`default_nettype none
// ============================================================================
// Module      : gpu_spi_frontend_multi
// Description : SPI (mode 0) slave register front end for a small polygon
//               GPU. A byte-oriented command/data protocol writes shadow
//               registers, which are copied to the active outputs by en_load.
// Revision    : 1.0 - initial release
// ============================================================================
module gpu_spi_frontend_multi #(
  parameter int NUM_POLY = 2,
  parameter int X_W      = 7,
  parameter int Y_W      = 6,
  parameter int COLOR_W  = 6,
  parameter int DEPTH_W  = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cs_in,
  input  logic                          sck_in,
  input  logic                          mosi_in,
  output logic                          miso_out,
  input  logic                          en_load,
  output logic [COLOR_W-1:0]            bg_color_out,
  output logic [NUM_POLY*COLOR_W-1:0]   poly_color_out,
  output logic [NUM_POLY*X_W-1:0]       v0_x_out,
  output logic [NUM_POLY*Y_W-1:0]       v0_y_out,
  output logic [NUM_POLY*X_W-1:0]       v1_x_out,
  output logic [NUM_POLY*Y_W-1:0]       v1_y_out,
  output logic [NUM_POLY*X_W-1:0]       v2_x_out,
  output logic [NUM_POLY*Y_W-1:0]       v2_y_out,
  output logic [NUM_POLY*DEPTH_W-1:0]   poly_depth_out,
  output logic [NUM_POLY-1:0]           poly_enable_out
);

  typedef enum logic [1:0] {IDLE = 2'd0, CMD = 2'd1, DATA = 2'd2} state_t;

  state_t       state, next_state;

  // Synchroniser stages plus one history bit for edge detection
  logic [1:0]   cs_sync, sck_sync, mosi_sync;
  logic         cs_prev, sck_prev;
  logic         cs_s, sck_rise, sck_fall, cs_fall, mosi_s;

  // Shift/datapath state
  logic [7:0]   shift;
  logic [2:0]   bit_cnt;
  logic         rw;
  logic [6:0]   addr;
  logic         load_pending;
  logic [7:0]   tx;
  logic         commit_valid;
  logic [6:0]   commit_addr;
  logic [7:0]   commit_data;
  logic [7:0]   rd_val;
  logic         byte_done;
  logic         unused_ok;

  // Shadow registers
  logic [COLOR_W-1:0] sh_bg;
  logic [COLOR_W-1:0] sh_color [NUM_POLY];
  logic [X_W-1:0]     sh_v0x   [NUM_POLY];
  logic [Y_W-1:0]     sh_v0y   [NUM_POLY];
  logic [X_W-1:0]     sh_v1x   [NUM_POLY];
  logic [Y_W-1:0]     sh_v1y   [NUM_POLY];
  logic [X_W-1:0]     sh_v2x   [NUM_POLY];
  logic [Y_W-1:0]     sh_v2y   [NUM_POLY];
  logic [DEPTH_W-1:0] sh_depth [NUM_POLY];
  logic [NUM_POLY-1:0] sh_en;

  // Active (output) registers
  logic [COLOR_W-1:0] out_color [NUM_POLY];
  logic [X_W-1:0]     out_v0x   [NUM_POLY];
  logic [Y_W-1:0]     out_v0y   [NUM_POLY];
  logic [X_W-1:0]     out_v1x   [NUM_POLY];
  logic [Y_W-1:0]     out_v1y   [NUM_POLY];
  logic [X_W-1:0]     out_v2x   [NUM_POLY];
  logic [Y_W-1:0]     out_v2y   [NUM_POLY];
  logic [DEPTH_W-1:0] out_depth [NUM_POLY];

  // cs resets low so a chip select already low at reset release never looks
  // like a falling edge; a frame then needs a fresh falling edge.
  assign cs_s      = cs_sync[1];
  assign mosi_s    = mosi_sync[1];
  assign cs_fall   = cs_prev & ~cs_s;
  assign sck_rise  = sck_sync[1] & ~sck_prev;
  assign sck_fall  = ~sck_sync[1] & sck_prev;
  assign byte_done = sck_rise && (bit_cnt == 3'd7) && (state != IDLE) && !cs_s;
  assign unused_ok = ^commit_data;

  // Two-stage synchronisers and edge history for the SPI pins
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cs_sync   <= '0;
      sck_sync  <= '0;
      mosi_sync <= '0;
      cs_prev   <= 1'b0;
      sck_prev  <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[0], cs_in};
      sck_sync  <= {sck_sync[0], sck_in};
      mosi_sync <= {mosi_sync[0], mosi_in};
      cs_prev   <= cs_s;
      sck_prev  <= sck_sync[1];
    end
  end

  // Frame state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Frame state transitions
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (cs_fall) next_state = CMD;
      CMD:     if (cs_s) next_state = IDLE;
               else if (byte_done) next_state = DATA;
      DATA:    if (cs_s) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Bit shifting, command decode, address counter, write staging and MISO
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift        <= '0;
      bit_cnt      <= '0;
      rw           <= 1'b0;
      addr         <= '0;
      load_pending <= 1'b0;
      tx           <= '0;
      miso_out     <= 1'b0;
      commit_valid <= 1'b0;
      commit_addr  <= '0;
      commit_data  <= '0;
    end else begin
      commit_valid <= 1'b0;
      if (state == IDLE || cs_s) begin
        bit_cnt      <= '0;
        load_pending <= 1'b0;
        tx           <= '0;
        miso_out     <= 1'b0;
      end else begin
        if (sck_rise) begin
          shift   <= {shift[6:0], mosi_s};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            if (state == CMD) begin
              rw           <= shift[6];
              addr         <= {shift[5:0], mosi_s};
              load_pending <= ~shift[6];
            end else begin
              if (rw) begin
                commit_valid <= 1'b1;
                commit_addr  <= addr;
                commit_data  <= {shift[6:0], mosi_s};
              end else begin
                load_pending <= 1'b1;
              end
              addr <= addr + 7'd1;
            end
          end
        end
        // Read data is fetched at the first falling edge after each byte
        if (sck_fall && state == DATA && !rw) begin
          if (load_pending) begin
            tx           <= rd_val;
            miso_out     <= rd_val[7];
            load_pending <= 1'b0;
          end else begin
            tx       <= {tx[6:0], 1'b0};
            miso_out <= tx[6];
          end
        end
      end
    end
  end

  // Read multiplexer: zero-extended shadow value, 0 for unmapped addresses
  always_comb begin
    rd_val = '0;
    if (addr[6:4] == 3'd0) begin
      if (addr[3:0] == 4'd0)      rd_val = 8'(sh_bg);
      else if (addr[3:0] == 4'hF) rd_val = 8'(NUM_POLY);
    end
    for (int p = 0; p < NUM_POLY; p++) begin
      if (addr[6:4] == 3'(p + 1)) begin
        case (addr[3:0])
          4'd0:    rd_val = 8'(sh_color[p]);
          4'd1:    rd_val = 8'(sh_v0x[p]);
          4'd2:    rd_val = 8'(sh_v0y[p]);
          4'd3:    rd_val = 8'(sh_v1x[p]);
          4'd4:    rd_val = 8'(sh_v1y[p]);
          4'd5:    rd_val = 8'(sh_v2x[p]);
          4'd6:    rd_val = 8'(sh_v2y[p]);
          4'd7:    rd_val = 8'(sh_depth[p]);
          4'd8:    rd_val = {7'd0, sh_en[p]};
          default: rd_val = '0;
        endcase
      end
    end
  end

  // Shadow register commit, one cycle after the data byte completes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_bg <= '0;
      sh_en <= '0;
      for (int p = 0; p < NUM_POLY; p++) begin
        sh_color[p] <= '0;
        sh_v0x[p]   <= '0;
        sh_v0y[p]   <= '0;
        sh_v1x[p]   <= '0;
        sh_v1y[p]   <= '0;
        sh_v2x[p]   <= '0;
        sh_v2y[p]   <= '0;
        sh_depth[p] <= '0;
      end
    end else if (commit_valid) begin
      if (commit_addr == 7'h00) sh_bg <= commit_data[COLOR_W-1:0];
      for (int p = 0; p < NUM_POLY; p++) begin
        if (commit_addr[6:4] == 3'(p + 1)) begin
          case (commit_addr[3:0])
            4'd0:    sh_color[p] <= commit_data[COLOR_W-1:0];
            4'd1:    sh_v0x[p]   <= commit_data[X_W-1:0];
            4'd2:    sh_v0y[p]   <= commit_data[Y_W-1:0];
            4'd3:    sh_v1x[p]   <= commit_data[X_W-1:0];
            4'd4:    sh_v1y[p]   <= commit_data[Y_W-1:0];
            4'd5:    sh_v2x[p]   <= commit_data[X_W-1:0];
            4'd6:    sh_v2y[p]   <= commit_data[Y_W-1:0];
            4'd7:    sh_depth[p] <= commit_data[DEPTH_W-1:0];
            4'd8:    sh_en[p]    <= commit_data[0];
            default: ;
          endcase
        end
      end
    end
  end

  // Active registers: snapshot of the shadows on en_load
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bg_color_out    <= '0;
      poly_enable_out <= '0;
      for (int p = 0; p < NUM_POLY; p++) begin
        out_color[p] <= '0;
        out_v0x[p]   <= '0;
        out_v0y[p]   <= '0;
        out_v1x[p]   <= '0;
        out_v1y[p]   <= '0;
        out_v2x[p]   <= '0;
        out_v2y[p]   <= '0;
        out_depth[p] <= '0;
      end
    end else if (en_load) begin
      bg_color_out    <= sh_bg;
      poly_enable_out <= sh_en;
      for (int p = 0; p < NUM_POLY; p++) begin
        out_color[p] <= sh_color[p];
        out_v0x[p]   <= sh_v0x[p];
        out_v0y[p]   <= sh_v0y[p];
        out_v1x[p]   <= sh_v1x[p];
        out_v1y[p]   <= sh_v1y[p];
        out_v2x[p]   <= sh_v2x[p];
        out_v2y[p]   <= sh_v2y[p];
        out_depth[p] <= sh_depth[p];
      end
    end
  end

  genvar gp;
  for (gp = 0; gp < NUM_POLY; gp++) begin : g_pack
    assign poly_color_out[gp*COLOR_W +: COLOR_W] = out_color[gp];
    assign v0_x_out[gp*X_W +: X_W]               = out_v0x[gp];
    assign v0_y_out[gp*Y_W +: Y_W]               = out_v0y[gp];
    assign v1_x_out[gp*X_W +: X_W]               = out_v1x[gp];
    assign v1_y_out[gp*Y_W +: Y_W]               = out_v1y[gp];
    assign v2_x_out[gp*X_W +: X_W]               = out_v2x[gp];
    assign v2_y_out[gp*Y_W +: Y_W]               = out_v2y[gp];
    assign poly_depth_out[gp*DEPTH_W +: DEPTH_W] = out_depth[gp];
  end

endmodule
`default_nettype wire

// File: tb/tb_gpu_spi_frontend_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpu_spi_frontend_multi
// Description : Self-checking bench for gpu_spi_frontend_multi. Expected read
//               bytes are queued when a read is issued and compared as the
//               bytes arrive on MISO.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpu_spi_frontend_multi;

  localparam int NP   = 2;
  localparam int XW   = 7;
  localparam int YW   = 6;
  localparam int CW   = 6;
  localparam int DW   = 3;
  localparam int HALF = 8;   // clk cycles per SPI half period (sck = clk/16)

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cs_in = 1'b1;
  logic             sck_in = 1'b0;
  logic             mosi_in = 1'b0;
  logic             en_load = 1'b0;
  logic             miso_out;
  logic [CW-1:0]    bg_color_out;
  logic [NP*CW-1:0] poly_color_out;
  logic [NP*XW-1:0] v0_x_out, v1_x_out, v2_x_out;
  logic [NP*YW-1:0] v0_y_out, v1_y_out, v2_y_out;
  logic [NP*DW-1:0] poly_depth_out;
  logic [NP-1:0]    poly_enable_out;

  int               n_checks = 0;
  int               n_pass   = 0;
  logic [7:0]       exp_q [$];
  logic [7:0]       rx;

  gpu_spi_frontend_multi #(
    .NUM_POLY(NP), .X_W(XW), .Y_W(YW), .COLOR_W(CW), .DEPTH_W(DW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cs_in           (cs_in),
    .sck_in          (sck_in),
    .mosi_in         (mosi_in),
    .miso_out        (miso_out),
    .en_load         (en_load),
    .bg_color_out    (bg_color_out),
    .poly_color_out  (poly_color_out),
    .v0_x_out        (v0_x_out),
    .v1_x_out        (v1_x_out),
    .v2_x_out        (v2_x_out),
    .v0_y_out        (v0_y_out),
    .v1_y_out        (v1_y_out),
    .v2_y_out        (v2_y_out),
    .poly_depth_out  (poly_depth_out),
    .poly_enable_out (poly_enable_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else             n_pass++;
  endtask

  task automatic pulse_load();
    @(negedge clk); en_load = 1'b1;
    @(negedge clk); en_load = 1'b0;
    @(negedge clk);
  endtask

  // One SPI byte, MSB first; MISO sampled just before each rising sck.
  // With coincide set, en_load is timed onto the commit edge of this byte.
  task automatic spi_byte(input logic [7:0] tx, input bit coincide,
                          input logic [7:0] old_val, output logic [7:0] rxb);
    for (int i = 7; i >= 0; i--) begin
      mosi_in = tx[i];
      repeat (HALF) @(negedge clk);
      rxb[i] = miso_out;
      sck_in = 1'b1;
      if (coincide && i == 0) begin
        repeat (3) @(posedge clk);
        @(negedge clk); en_load = 1'b1;
        @(negedge clk); en_load = 1'b0;
        check("coincide_old", 32'(bg_color_out), 32'(old_val));
        repeat (HALF - 4) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      sck_in = 1'b0;
    end
  endtask

  task automatic spi_begin();
    @(negedge clk);
    cs_in = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic spi_end();
    repeat (HALF) @(negedge clk);
    cs_in = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic spi_write(input logic [7:0] cmd, input logic [23:0] data, input int n);
    logic [7:0] r;
    spi_begin();
    spi_byte(cmd, 1'b0, 8'h00, r);
    for (int k = 0; k < n; k++) spi_byte(data[8*(n-1-k) +: 8], 1'b0, 8'h00, r);
    spi_end();
  endtask

  task automatic spi_read(input logic [7:0] cmd, input int n);
    logic [7:0] r;
    logic [7:0] e;
    spi_begin();
    spi_byte(cmd, 1'b0, 8'h00, r);
    check("miso_during_cmd", 32'(r), 32'h0);
    for (int k = 0; k < n; k++) begin
      spi_byte(8'h00, 1'b0, 8'h00, r);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      check("miso_read", 32'(r), 32'(e));
    end
    spi_end();
    check("miso_idle", 32'(miso_out), 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_bg",    32'(bg_color_out),    32'h0);
    check("rst_color", 32'(poly_color_out),  32'h0);
    check("rst_v0x",   32'(v0_x_out),        32'h0);
    check("rst_depth", 32'(poly_depth_out),  32'h0);
    check("rst_en",    32'(poly_enable_out), 32'h0);
    check("rst_miso",  32'(miso_out),        32'h0);

    // Background colour write, visible only after en_load
    spi_write(8'h80, 24'h00002A, 1);
    check("bg_before_load", 32'(bg_color_out), 32'h0);
    pulse_load();
    check("bg_after_load", 32'(bg_color_out), 32'h2A);

    // Undefined slot-0 field: write ignored, reads back 0
    spi_write(8'h81, 24'h000015, 1);
    exp_q.push_back(8'h00);
    spi_read(8'h01, 1);

    // Burst write into poly0 v0x, v0y, v1x
    spi_write(8'h91, 24'h050607, 3);
    pulse_load();
    check("p0_v0x", 32'(v0_x_out[XW-1:0]), 32'h05);
    check("p0_v0y", 32'(v0_y_out[YW-1:0]), 32'h06);
    check("p0_v1x", 32'(v1_x_out[XW-1:0]), 32'h07);
    check("p1_v0x", 32'(v0_x_out[2*XW-1:XW]), 32'h00);
    exp_q.push_back(8'h05); exp_q.push_back(8'h06); exp_q.push_back(8'h07);
    spi_read(8'h11, 3);

    // Poly1 enable, ID register, unmapped slot
    spi_write(8'hA8, 24'h000001, 1);
    exp_q.push_back(8'h01); spi_read(8'h28, 1);
    exp_q.push_back(8'h02); spi_read(8'h0F, 1);
    exp_q.push_back(8'h00); spi_read(8'h30, 1);
    pulse_load();
    check("enable_out", 32'(poly_enable_out), 32'h2);

    // Abort after 4 data bits of a depth write
    spi_begin();
    spi_byte(8'h97, 1'b0, 8'h00, rx);
    for (int i = 0; i < 4; i++) begin
      mosi_in = 1'b1;
      repeat (HALF) @(negedge clk);
      sck_in = 1'b1;
      repeat (HALF) @(negedge clk);
      sck_in = 1'b0;
    end
    cs_in = 1'b1;
    repeat (2 * HALF) @(negedge clk);
    exp_q.push_back(8'h00); spi_read(8'h17, 1);

    // Address wrap 0x7F -> 0x00, and ID is read-only
    exp_q.push_back(8'h00); exp_q.push_back(8'h2A);
    spi_read(8'h7F, 2);
    spi_write(8'h8F, 24'h000055, 1);
    exp_q.push_back(8'h02); spi_read(8'h0F, 1);

    // en_load on the commit edge takes the old value
    spi_begin();
    spi_byte(8'h80, 1'b0, 8'h00, rx);
    spi_byte(8'h15, 1'b1, 8'h2A, rx);
    spi_end();
    check("coincide_hold", 32'(bg_color_out), 32'h2A);
    pulse_load();
    check("coincide_next", 32'(bg_color_out), 32'h15);

    // Reset in the middle of a burst
    spi_begin();
    spi_byte(8'h91, 1'b0, 8'h00, rx);
    spi_byte(8'h11, 1'b0, 8'h00, rx);
    for (int i = 0; i < 3; i++) begin
      mosi_in = 1'b1;
      repeat (HALF) @(negedge clk);
      sck_in = 1'b1;
      repeat (HALF) @(negedge clk);
      sck_in = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("mrst_bg",   32'(bg_color_out),    32'h0);
    check("mrst_v0x",  32'(v0_x_out),        32'h0);
    check("mrst_en",   32'(poly_enable_out), 32'h0);
    check("mrst_miso", 32'(miso_out),        32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      mosi_in = 1'b1;
      repeat (HALF) @(negedge clk);
      sck_in = 1'b1;
      repeat (HALF) @(negedge clk);
      sck_in = 1'b0;
    end
    cs_in = 1'b1;
    repeat (2 * HALF) @(negedge clk);
    pulse_load();
    check("post_rst_v0x", 32'(v0_x_out), 32'h0);
    spi_write(8'h80, 24'h000033, 1);
    pulse_load();
    check("post_rst_bg", 32'(bg_color_out), 32'h33);
    exp_q.push_back(8'h00); spi_read(8'h11, 1);

    check("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
